mismatch_scanner: RTL

//  Inverse of the team's 8-bit equality tester: that block reduces num1^num2 to one

---
 rtl/mismatch_scanner_if.sv | 28 ++
 rtl/mismatch_scanner.sv | 84 ++++++++
 2 files changed

// File: rtl/mismatch_scanner_if.sv
// Handshake and operand bundle for mismatch_scanner: operand capture on start,
// per-bit index stream with valid/ready, and the end-of-scan summary.
interface mismatch_scanner_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             busy;
  logic             idx_valid;
  logic [IDX_W-1:0] idx;
  logic             idx_ready;
  logic             done;
  logic             equal;
  logic [IDX_W:0]   diff_count;

  modport master (
    output start, num1, num2, idx_ready,
    input  busy, idx_valid, idx, done, equal, diff_count
  );

  modport slave (
    input  start, num1, num2, idx_ready,
    output busy, idx_valid, idx, done, equal, diff_count
  );
endinterface

// File: rtl/mismatch_scanner.sv
// Expands num1^num2 into a stream of differing bit indices (LSB first), one per
// handshake, followed by a one-cycle done pulse with match summary.
module mismatch_scanner #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  mismatch_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W:0]   cnt_reg;
  logic             done_reg;
  logic             equal_reg;
  logic [IDX_W:0]   diff_count_reg;

  logic             hit;
  logic             take;
  logic             last;
  logic [IDX_W:0]   cnt_next;

  // idx_valid is decoded only from registers so idx_ready never reaches it combinationally.
  always_comb begin
    hit      = (state_reg == SCAN) && diff_reg[ptr_reg];
    take     = !hit || bus.idx_ready;
    last     = (ptr_reg == IDX_W'(WIDTH - 1));
    cnt_next = cnt_reg + {{IDX_W{1'b0}}, hit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      diff_reg       <= '0;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      done_reg       <= 1'b0;
      equal_reg      <= 1'b0;
      diff_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            diff_reg       <= bus.num1 ^ bus.num2;
            ptr_reg        <= '0;
            cnt_reg        <= '0;
            equal_reg      <= 1'b0;
            diff_count_reg <= '0;
            state_reg      <= SCAN;
          end
        end
        SCAN: begin
          if (take) begin
            cnt_reg <= cnt_next;
            if (last) begin
              // Summary is latched here so it is visible for the whole DONE cycle.
              state_reg      <= DONE;
              done_reg       <= 1'b1;
              equal_reg      <= (cnt_next == '0);
              diff_count_reg <= cnt_next;
            end else begin
              ptr_reg <= ptr_reg + IDX_W'(1);
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.idx_valid  = hit;
  assign bus.idx        = ptr_reg;
  assign bus.done       = done_reg;
  assign bus.equal      = equal_reg;
  assign bus.diff_count = diff_count_reg;
endmodule
